// File: rtl/output_spi_pkg.sv
// Shared types and constants for the output_spi SPI master transmitter.
// Bit order is selected by the OUTPUT_SPI_LSB_FIRST_EN macro (see output_spi.sv).
package output_spi_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_e;

    localparam int BITS_PER_FRAME = 8;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return w;
    endfunction

    // A divide-by-1 still needs a one-bit counter to keep the port widths legal.
    function automatic int cnt_width(input int div);
        return (clog2(div) < 1) ? 1 : clog2(div);
    endfunction

endpackage

// File: rtl/output_spi_clk_div.sv
// SCLK half-period divider: emits a one-cycle half_tick_o every CLK_DIV cycles.
// Held at zero while clear_i is high so every frame starts from a known phase.
module spi_clk_div
    import output_spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic half_tick_o
);

    localparam int CNT_W = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        half_tick_o = !clear_i && (cnt_q == LAST);
        cnt_d       = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/output_spi.sv
// Byte-wide SPI mode-0 master transmitter driving ciphertext to an external slave.
// MSB first by default; define OUTPUT_SPI_LSB_FIRST_EN for LSB-first framing.
module output_spi
    import output_spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = BITS_PER_FRAME
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] in,
    output logic              out,
    output logic              clk_out,
    output logic              en_out,
    output logic              sent,
    output state_e            state_dbg
);

    localparam int BC_W = $clog2(DATA_W + 1);
`ifdef OUTPUT_SPI_LSB_FIRST_EN
    localparam int LEAD = 0;
`else
    localparam int LEAD = DATA_W - 1;
`endif

    state_e            state_q;
    logic [DATA_W-1:0] sreg_q;
    logic [DATA_W-1:0] sreg_d;
    logic [BC_W-1:0]   bit_cnt_q;
    logic              out_q;
    logic              clk_out_q;
    logic              en_out_q;
    logic              sent_q;
    logic              half_tick;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (state_q == IDLE),
        .half_tick_o (half_tick)
    );

    // The shift moves the next bit to send into the LEAD position.
    always_comb begin
`ifdef OUTPUT_SPI_LSB_FIRST_EN
        sreg_d = {1'b0, sreg_q[DATA_W-1:1]};
`else
        sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            out_q     <= 1'b0;
            clk_out_q <= 1'b0;
            en_out_q  <= 1'b1;
            sent_q    <= 1'b0;
        end else begin
            sent_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    en_out_q  <= 1'b1;
                    clk_out_q <= 1'b0;
                    out_q     <= 1'b0;
                    if (!en) begin
                        sreg_q    <= in;
                        out_q     <= in[LEAD];
                        en_out_q  <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (half_tick) state_q <= SHIFT;
                end
                SHIFT: begin
                    if (half_tick) begin
                        if (!clk_out_q) begin
                            clk_out_q <= 1'b1;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end else begin
                            clk_out_q <= 1'b0;
                            // Last falling edge closes the frame instead of shifting.
                            if (bit_cnt_q == BC_W'(DATA_W)) begin
                                state_q  <= DONE;
                                en_out_q <= 1'b1;
                                out_q    <= 1'b0;
                                sent_q   <= 1'b1;
                            end else begin
                                sreg_q <= sreg_d;
                                out_q  <= sreg_d[LEAD];
                            end
                        end
                    end
                end
                DONE: begin
                    if (half_tick) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out       = out_q;
    assign clk_out   = clk_out_q;
    assign en_out    = en_out_q;
    assign sent      = sent_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_output_spi.sv
// Self-checking bench for output_spi (CLK_DIV=2): table vectors, directed corner
// sequences and randomized frames checked against a bit-order reference model.
module tb_output_spi;
    import output_spi_pkg::*;

    localparam int CLK_DIV = 2;
    localparam int LAT     = 17 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [7:0] in_b = 8'h00;
    logic       out_s;
    logic       clk_out;
    logic       en_out;
    logic       sent;
    state_e     state_dbg;

    always #5 clk = ~clk;

    output_spi #(.CLK_DIV(CLK_DIV), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in        (in_b),
        .out       (out_s),
        .clk_out   (clk_out),
        .en_out    (en_out),
        .sent      (sent),
        .state_dbg (state_dbg)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq_msb;
        logic [7:0] seq_lsb;
    } vec_t;

    vec_t       vecs[6];
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         nbits = 0;
    int         sent_cnt = 0;
    int         fall_cyc = 0;
    int         rise_cyc = 0;
    int         last_gap = 0;
    logic [7:0] seq = 8'h00;
    logic       prev_clk = 1'b0;
    logic       prev_en_out = 1'b1;
    logic       prev_sent = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: sequence of bits the slave sees, first sampled bit placed at [7].
    function automatic logic [7:0] model_seq(input logic [7:0] b);
        logic [7:0] s;
        for (int i = 0; i < 8; i++) begin
`ifdef OUTPUT_SPI_LSB_FIRST_EN
            s[7-i] = b[i];
`else
            s[7-i] = b[7-i];
`endif
        end
        return s;
    endfunction

    // Monitor: samples on the falling clk edge, away from the DUT's active edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            nbits = 0;
            seq   = 8'h00;
        end else begin
            if (clk_out === 1'b1 && prev_clk === 1'b0) begin
                check("sclk_rise_selected", en_out, 0);
                nbits++;
                seq = {seq[6:0], out_s};
            end
            if (en_out === 1'b0 && prev_en_out === 1'b1) begin
                last_gap = cyc - rise_cyc;
                fall_cyc = cyc;
                nbits    = 0;
            end
            if (en_out === 1'b1 && prev_en_out === 1'b0) rise_cyc = cyc;
            if (sent === 1'b1) begin
                sent_cnt++;
                check("sent_one_cycle", prev_sent, 0);
                check("latency", cyc - fall_cyc, LAT);
                check("bit_count", nbits, 8);
                check("sent_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("frame_bits", seq, exp_q.pop_front());
                nbits = 0;
            end
        end
        prev_clk    = clk_out;
        prev_en_out = en_out;
        prev_sent   = sent;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_sent(input int target, input string name);
        int k;
        k = 0;
        while (sent_cnt < target && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, sent_cnt, target);
    endtask

    task automatic start_frame(input logic [7:0] b, input logic [7:0] s);
        in_b = b;
        en   = 1'b0;
        exp_q.push_back(s);
        tick(1);
        en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        int         k;
        logic [7:0] b;
        logic [7:0] es;

        vecs[0] = '{8'h01, 8'h01, 8'h80};
        vecs[1] = '{8'hA5, 8'hA5, 8'hA5};
        vecs[2] = '{8'h02, 8'h02, 8'h40};
        vecs[3] = '{8'hF0, 8'hF0, 8'h0F};
        vecs[4] = '{8'h3C, 8'h3C, 8'h3C};
        vecs[5] = '{8'h80, 8'h80, 8'h01};

        // Reset held with en high.
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_out", out_s, 0);
            check("rst_clk_out", clk_out, 0);
            check("rst_en_out", en_out, 1);
            check("rst_sent", sent, 0);
            check("rst_state", state_dbg, IDLE);
        end
        rst = 1'b0;
        tick(2);

        // Table-driven single frames.
        for (int i = 0; i < 6; i++) begin
`ifdef OUTPUT_SPI_LSB_FIRST_EN
            es = vecs[i].seq_lsb;
`else
            es = vecs[i].seq_msb;
`endif
            base = sent_cnt;
            start_frame(vecs[i].data, es);
            check("vec_select_low", en_out, 0);
            wait_sent(base + 1, "vec_sent");
            tick(CLK_DIV + 1);
            check("vec_back_idle", state_dbg, IDLE);
            check("vec_idle_en_out", en_out, 1);
        end

        // Back to back with en held low; in changes during frame 1.
        base = sent_cnt;
        in_b = 8'h01;
        en   = 1'b0;
        exp_q.push_back(model_seq(8'h01));
        exp_q.push_back(model_seq(8'h02));
        tick(1);
        check("b2b_first_select", en_out, 0);
        tick(5);
        in_b = 8'h02;
        wait_sent(base + 1, "b2b_sent1");
        k = 0;
        while (en_out !== 1'b0 && k < 20) begin
            tick(1);
            k++;
        end
        en   = 1'b1;
        in_b = 8'($urandom);
        check("b2b_restart", en_out, 0);
        wait_sent(base + 2, "b2b_sent2");
        check("b2b_gap", last_gap, CLK_DIV + 1);
        tick(CLK_DIV + 1);

        // Reset after the third SCLK rising edge abandons the frame.
        base = sent_cnt;
        start_frame(8'hC3, model_seq(8'hC3));
        k = 0;
        while (nbits < 3 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("mid_rise_count", nbits, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_en_out", en_out, 1);
        check("mid_clk_out", clk_out, 0);
        check("mid_out", out_s, 0);
        check("mid_sent", sent, 0);
        void'(exp_q.pop_back());
        tick(1);
        rst = 1'b0;
        tick(60);
        check("mid_no_sent", sent_cnt, base);
        check("mid_idle", state_dbg, IDLE);

        // en and in wiggle while a frame is in flight.
        base = sent_cnt;
        b = 8'($urandom);
        start_frame(b, model_seq(b));
        repeat (20) begin
            en   = 1'($urandom_range(0, 1));
            in_b = 8'($urandom);
            tick(1);
        end
        en = 1'b1;
        wait_sent(base + 1, "toggle_sent");
        tick(CLK_DIV + 1);

        // Randomized frames with random idle gaps.
        repeat (16) begin
            base = sent_cnt;
            b = 8'($urandom_range(0, 255));
            start_frame(b, model_seq(b));
            wait_sent(base + 1, "rand_sent");
            tick(CLK_DIV + 1 + $urandom_range(0, 4));
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
